// File: rtl/ssm_tile_feeder_if.sv
// Tile-side bus of the SSM tile feeder: tile memory read port and the tile output stream.
// master = feeder, slave = memory/downstream consumer.
interface ssm_tile_feeder_if #(
    parameter int unsigned DW     = 16,
    parameter int unsigned N_TILE = 16,
    parameter int unsigned ADDR_W = 8
);
    // Tile memory read port
    logic                   mem_rd_en_o;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic [N_TILE*DW-1:0]   mem_B_i;
    logic [N_TILE*DW-1:0]   mem_C_i;
    logic [N_TILE*DW-1:0]   mem_h_i;

    // Tile output stream
    logic                   tile_valid_o;
    logic                   tile_ready_i;
    logic                   tile_last_o;
    logic [N_TILE*DW-1:0]   B_tile_o;
    logic [N_TILE*DW-1:0]   C_tile_o;
    logic [N_TILE*DW-1:0]   hprev_tile_o;

    modport master (
        output mem_rd_en_o, mem_addr_o,
        input  mem_B_i, mem_C_i, mem_h_i,
        output tile_valid_o, tile_last_o, B_tile_o, C_tile_o, hprev_tile_o,
        input  tile_ready_i
    );

    modport slave (
        input  mem_rd_en_o, mem_addr_o,
        output mem_B_i, mem_C_i, mem_h_i,
        input  tile_valid_o, tile_last_o, B_tile_o, C_tile_o, hprev_tile_o,
        output tile_ready_i
    );
endinterface

// File: rtl/ssm_tile_feeder.sv
// SSM tile feeder: latches frame scalars on start, reads B/C/hprev tiles from a fixed-latency
// tile memory and streams them through a credit-gated output FIFO with valid/ready/last.
// Optional macro SSM_FEEDER_PERF_EN adds stall/starve performance counters.
module ssm_tile_feeder #(
    parameter int unsigned DW      = 16,
    parameter int unsigned N_TILE  = 16,
    parameter int unsigned N_STATE = 128,
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned FIFO_D  = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start_i,
    input  logic [DW-1:0] dt_i,
    input  logic [DW-1:0] dA_i,
    input  logic [DW-1:0] x_i,
    input  logic [DW-1:0] D_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW-1:0] dt_o,
    output logic [DW-1:0] dA_o,
    output logic [DW-1:0] x_o,
    output logic [DW-1:0] D_o,
`ifdef SSM_FEEDER_PERF_EN
    output logic [31:0]   stall_cnt_o,
    output logic [31:0]   starve_cnt_o,
`endif
    ssm_tile_feeder_if.master tile_if
);

    localparam int unsigned NTiles = N_STATE / N_TILE;
    localparam int unsigned TileW  = N_TILE * DW;
    localparam int unsigned PtrW   = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int unsigned CntW   = $clog2(FIFO_D + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e            state_q, state_d;
    logic              start_acc;
    logic              rd_en;
    logic              issue_last;
    logic [ADDR_W-1:0] issue_idx_q;

    logic [MEM_LAT-1:0] sr_valid_q;
    logic [MEM_LAT-1:0] sr_last_q;
    int unsigned        inflight;

    logic              push, push_last, pop;
    logic              fifo_empty, fifo_full;
    logic [CntW-1:0]   fifo_count_q;
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [TileW-1:0]  fifo_b_q [FIFO_D];
    logic [TileW-1:0]  fifo_c_q [FIFO_D];
    logic [TileW-1:0]  fifo_h_q [FIFO_D];
    logic [FIFO_D-1:0] fifo_last_q;

    logic              done_q;
    logic [DW-1:0]     dt_q, dA_q, x_q, D_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign start_acc  = (state_q == StIdle) && start_i;
    assign issue_last = (issue_idx_q == ADDR_W'(NTiles - 1));
    assign push       = sr_valid_q[MEM_LAT-1];
    assign push_last  = sr_last_q[MEM_LAT-1];
    assign fifo_empty = (fifo_count_q == '0);
    assign fifo_full  = (fifo_count_q == CntW'(FIFO_D));
    assign pop        = !fifo_empty && tile_if.tile_ready_i;

    // Reads still travelling through the latency line, excluding the tail being pushed now.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < int'(MEM_LAT) - 1; i++) begin
            inflight += 32'(sr_valid_q[i]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next state and credit-gated read strobe; a pop does not free a credit until next cycle.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StIssue;
            end
            StIssue: begin
                rd_en = (32'(fifo_count_q) + inflight + 32'(push)) < FIFO_D;
                if (rd_en && issue_last) state_d = StDrain;
            end
            StDrain: begin
                if (pop && tile_if.tile_last_o && (fifo_count_q == CntW'(1)) &&
                    (inflight == 0) && !push) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Tile index counter, restarted on every accepted start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)          issue_idx_q <= '0;
        else if (start_acc) issue_idx_q <= '0;
        else if (rd_en)     issue_idx_q <= issue_idx_q + 1'b1;
    end

    // Latency line carrying {valid, last} so the tail lines up with returning rdata.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_valid_q <= '0;
            sr_last_q  <= '0;
        end else begin
            sr_valid_q[0] <= rd_en;
            sr_last_q[0]  <= rd_en && issue_last;
            for (int i = 1; i < int'(MEM_LAT); i++) begin
                sr_valid_q[i] <= sr_valid_q[i-1];
                sr_last_q[i]  <= sr_last_q[i-1];
            end
        end
    end

    // Output FIFO; the head is read straight from registers so data holds while stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_last_q  <= '0;
            for (int i = 0; i < int'(FIFO_D); i++) begin
                fifo_b_q[i] <= '0;
                fifo_c_q[i] <= '0;
                fifo_h_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_b_q[wr_ptr_q]    <= tile_if.mem_B_i;
                fifo_c_q[wr_ptr_q]    <= tile_if.mem_C_i;
                fifo_h_q[wr_ptr_q]    <= tile_if.mem_h_i;
                fifo_last_q[wr_ptr_q] <= push_last;
                wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      fifo_count_q <= fifo_count_q + 1'b1;
            else if (!push && pop) fifo_count_q <= fifo_count_q - 1'b1;
        end
    end

    // Credits make overflow impossible; firing here means the credit check is broken.
    overflow_a: assert property (@(posedge clk) disable iff (!rstn) !(push && fifo_full && !pop));

    // Done pulses the cycle after the last tile handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) done_q <= 1'b0;
        else       done_q <= (state_q == StDrain) && pop && tile_if.tile_last_o;
    end

    // Frame scalars, held until the next accepted start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dt_q <= '0;
            dA_q <= '0;
            x_q  <= '0;
            D_q  <= '0;
        end else if (start_acc) begin
            dt_q <= dt_i;
            dA_q <= dA_i;
            x_q  <= x_i;
            D_q  <= D_i;
        end
    end

`ifdef SSM_FEEDER_PERF_EN
    logic [31:0] stall_cnt_q, starve_cnt_q;

    // Saturating stall/starve counters, cleared on accepted start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else if (start_acc) begin
            stall_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            if (!fifo_empty && !tile_if.tile_ready_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if ((state_q != StIdle) && fifo_empty && (starve_cnt_q != '1)) begin
                starve_cnt_q <= starve_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign starve_cnt_o = starve_cnt_q;
`endif

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign dt_o   = dt_q;
    assign dA_o   = dA_q;
    assign x_o    = x_q;
    assign D_o    = D_q;

    assign tile_if.mem_rd_en_o  = rd_en;
    assign tile_if.mem_addr_o   = issue_idx_q;
    assign tile_if.tile_valid_o = !fifo_empty;
    assign tile_if.tile_last_o  = !fifo_empty && fifo_last_q[rd_ptr_q];
    assign tile_if.B_tile_o     = fifo_b_q[rd_ptr_q];
    assign tile_if.C_tile_o     = fifo_c_q[rd_ptr_q];
    assign tile_if.hprev_tile_o = fifo_h_q[rd_ptr_q];

endmodule

// File: tb/tb_ssm_tile_feeder.sv
// Directed self-checking bench for ssm_tile_feeder (N_STATE=128, N_TILE=16, MEM_LAT=2, FIFO_D=4).
// Build with SSM_FEEDER_PERF_EN defined to also exercise the performance counters.
module tb_ssm_tile_feeder;

    localparam int unsigned DW     = 16;
    localparam int unsigned N_TILE = 16;
    localparam int unsigned ADDR_W = 8;

    logic          clk, rstn, start_i, busy_o, done_o;
    logic [DW-1:0] dt_i, dA_i, x_i, D_i, dt_o, dA_o, x_o, D_o;
`ifdef SSM_FEEDER_PERF_EN
    logic [31:0]   stall_cnt_o, starve_cnt_o;
`endif

    ssm_tile_feeder_if #(.DW(DW), .N_TILE(N_TILE), .ADDR_W(ADDR_W)) tif ();

    ssm_tile_feeder #(
        .DW(16), .N_TILE(16), .N_STATE(128), .MEM_LAT(2), .ADDR_W(8), .FIFO_D(4)
    ) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i),
        .dt_i(dt_i), .dA_i(dA_i), .x_i(x_i), .D_i(D_i),
        .busy_o(busy_o), .done_o(done_o),
        .dt_o(dt_o), .dA_o(dA_o), .x_o(x_o), .D_o(D_o),
`ifdef SSM_FEEDER_PERF_EN
        .stall_cnt_o(stall_cnt_o), .starve_cnt_o(starve_cnt_o),
`endif
        .tile_if(tif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lane j of tile t carries {tag, t, j}.
    function automatic logic [255:0] tile_data(input logic [7:0] t, input logic [3:0] tag);
        logic [255:0] d;
        d = '0;
        for (int j = 0; j < 16; j++) d[j*16 +: 16] = {tag, t[3:0], 8'(j)};
        return d;
    endfunction

    // Tile memory: rdata valid two cycles after the strobe cycle.
    logic [7:0] m_a0 = '0;
    logic [7:0] m_a1 = '0;
    always @(posedge clk) begin
        m_a0 <= tif.mem_addr_o;
        m_a1 <= m_a0;
    end
    assign tif.mem_B_i = tile_data(m_a1, 4'hB);
    assign tif.mem_C_i = tile_data(m_a1, 4'hC);
    assign tif.mem_h_i = tile_data(m_a1, 4'hA);

    int checks = 0;
    int errors = 0;

    // Per-frame observations.
    int   n_hs, n_strobe, strobes_early, first_valid_c, last_c, done_c, max_occ;
    int   hold_errs, data_errs, stall_seen, starve_seen;
    int   rec_tile [32];
    int   rec_addr [32];
    logic rec_last [32];
    bit   done_seen, busy_at_done;

    function automatic logic ready_pat(input int mode, input int c);
        case (mode)
            1:       return (c % 4 == 0) || (c % 4 == 3);
            2:       return c >= 20;
            default: return 1'b1;
        endcase
    endfunction

    // Counts tiles whose index, last flag or issue address differs from position order.
    function automatic int order_errs(input int n);
        int e;
        e = 0;
        for (int k = 0; k < n; k++) begin
            if (rec_tile[k] != k || rec_last[k] !== (k == n - 1) || rec_addr[k] != k) e++;
        end
        return e;
    endfunction

    task automatic do_start(input logic [15:0] dt, input logic [15:0] da,
                            input logic [15:0] x, input logic [15:0] d);
        start_i = 1'b1; dt_i = dt; dA_i = da; x_i = x; D_i = d;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Observes one frame from cycle 0 (first cycle after the accepting edge).
    task automatic run_frame(input int mode, input int max_cycles, input int restart_c,
                             input int abort_after);
        bit           hold_pend;
        logic [255:0] hold_b;
        logic         hold_last;
        logic [7:0]   idx;
        n_hs = 0; n_strobe = 0; strobes_early = 0; first_valid_c = -1; last_c = -1;
        done_c = -1; max_occ = 0; hold_errs = 0; data_errs = 0; stall_seen = 0;
        starve_seen = 0; done_seen = 0; busy_at_done = 0; hold_pend = 0;
        hold_b = '0; hold_last = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            tif.tile_ready_i = ready_pat(mode, c);
            if (c == restart_c) begin
                start_i = 1'b1;
                x_i = 16'h4000;
            end else begin
                start_i = 1'b0;
            end
            if (hold_pend && (!tif.tile_valid_o || tif.B_tile_o !== hold_b ||
                              tif.tile_last_o !== hold_last)) hold_errs++;
            hold_pend = 0;
            if (busy_o && !tif.tile_valid_o) starve_seen++;
            if (tif.tile_valid_o && first_valid_c < 0) first_valid_c = c;
            if (tif.mem_rd_en_o) begin
                if (n_strobe < 32) rec_addr[n_strobe] = int'(tif.mem_addr_o);
                n_strobe++;
                if (c < 20) strobes_early++;
            end
            if (tif.tile_valid_o) begin
                if (tif.tile_ready_i) begin
                    idx = {4'h0, tif.B_tile_o[11:8]};
                    if (n_hs < 32) begin
                        rec_tile[n_hs] = int'(idx);
                        rec_last[n_hs] = tif.tile_last_o;
                    end
                    if (tif.B_tile_o !== tile_data(idx, 4'hB) ||
                        tif.C_tile_o !== tile_data(idx, 4'hC) ||
                        tif.hprev_tile_o !== tile_data(idx, 4'hA)) data_errs++;
                    n_hs++;
                    last_c = c;
                end else begin
                    stall_seen++;
                    hold_pend = 1;
                    hold_b = tif.B_tile_o;
                    hold_last = tif.tile_last_o;
                end
            end
            if (n_strobe - n_hs > max_occ) max_occ = n_strobe - n_hs;
            if (done_o) begin
                done_seen = 1;
                done_c = c;
                busy_at_done = busy_o;
                break;
            end
            @(negedge clk);
            if (abort_after > 0 && n_hs >= abort_after) break;
        end
        start_i = 1'b0;
        tif.tile_ready_i = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; start_i = 1'b0; tif.tile_ready_i = 1'b1;
        dt_i = '0; dA_i = '0; x_i = '0; D_i = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (tif.tile_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", tif.tile_valid_o); end
        checks++; if (tif.mem_rd_en_o !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", tif.mem_rd_en_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
        checks++; if (dt_o !== 16'h0) begin errors++; $display("FAIL reset_dt got=%h exp=0", dt_o); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal;
        do_start(16'h3C00, 16'hBC00, 16'h3800, 16'h4200);
        run_frame(0, 60, -1, 0);
        checks++; if (!done_seen) begin errors++; $display("FAIL t1_done got=0 exp=1"); end
        checks++; if (n_hs !== 8) begin errors++; $display("FAIL t1_tiles got=%0d exp=8", n_hs); end
        checks++; if (n_strobe !== 8) begin errors++; $display("FAIL t1_strobes got=%0d exp=8", n_strobe); end
        checks++; if (order_errs(8) !== 0) begin errors++; $display("FAIL t1_order got=%0d exp=0", order_errs(8)); end
        checks++; if (first_valid_c !== 3) begin errors++; $display("FAIL t1_first_valid got=%0d exp=3", first_valid_c); end
        checks++; if (last_c !== 10) begin errors++; $display("FAIL t1_last_hs got=%0d exp=10", last_c); end
        checks++; if (done_c !== 11) begin errors++; $display("FAIL t1_done_cycle got=%0d exp=11", done_c); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL t1_busy_at_done got=1 exp=0"); end
        checks++; if (data_errs !== 0) begin errors++; $display("FAIL t1_data got=%0d exp=0", data_errs); end
        checks++; if (dt_o !== 16'h3C00) begin errors++; $display("FAIL t1_dt got=%h exp=3c00", dt_o); end
        checks++; if (dA_o !== 16'hBC00) begin errors++; $display("FAIL t1_dA got=%h exp=bc00", dA_o); end
        checks++; if (x_o !== 16'h3800) begin errors++; $display("FAIL t1_x got=%h exp=3800", x_o); end
        checks++; if (D_o !== 16'h4200) begin errors++; $display("FAIL t1_D got=%h exp=4200", D_o); end
        @(negedge clk);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got=1 exp=0"); end
        checks++; if (dt_o !== 16'h3C00) begin errors++; $display("FAIL t1_dt_hold got=%h exp=3c00", dt_o); end
    endtask

    task automatic test_backpressure;
        do_start(16'h1234, 16'h0001, 16'h0002, 16'h0003);
        run_frame(1, 80, -1, 0);
        checks++; if (!done_seen) begin errors++; $display("FAIL t2_done got=0 exp=1"); end
        checks++; if (n_hs !== 8) begin errors++; $display("FAIL t2_tiles got=%0d exp=8", n_hs); end
        checks++; if (order_errs(8) !== 0) begin errors++; $display("FAIL t2_order got=%0d exp=0", order_errs(8)); end
        checks++; if (hold_errs !== 0) begin errors++; $display("FAIL t2_hold got=%0d exp=0", hold_errs); end
        checks++; if (max_occ > 4) begin errors++; $display("FAIL t2_occupancy got=%0d exp<=4", max_occ); end
        checks++; if (data_errs !== 0) begin errors++; $display("FAIL t2_data got=%0d exp=0", data_errs); end
    endtask

    task automatic test_ready_low;
        do_start(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        run_frame(2, 80, -1, 0);
        checks++; if (strobes_early !== 4) begin errors++; $display("FAIL t3_strobes got=%0d exp=4", strobes_early); end
        checks++; if (max_occ !== 4) begin errors++; $display("FAIL t3_occupancy got=%0d exp=4", max_occ); end
        checks++; if (!done_seen) begin errors++; $display("FAIL t3_done got=0 exp=1"); end
        checks++; if (n_hs !== 8) begin errors++; $display("FAIL t3_tiles got=%0d exp=8", n_hs); end
        checks++; if (order_errs(8) !== 0) begin errors++; $display("FAIL t3_order got=%0d exp=0", order_errs(8)); end
        checks++; if (data_errs !== 0) begin errors++; $display("FAIL t3_data got=%0d exp=0", data_errs); end
    endtask

    task automatic test_busy_start;
        do_start(16'h0A0A, 16'h0B0B, 16'h1111, 16'h0D0D);
        run_frame(0, 60, 3, 0);
        checks++; if (x_o !== 16'h1111) begin errors++; $display("FAIL t4_x got=%h exp=1111", x_o); end
        checks++; if (!done_seen) begin errors++; $display("FAIL t4_done got=0 exp=1"); end
        checks++; if (n_hs !== 8) begin errors++; $display("FAIL t4_tiles got=%0d exp=8", n_hs); end
        checks++; if (n_strobe !== 8) begin errors++; $display("FAIL t4_strobes got=%0d exp=8", n_strobe); end
        checks++; if (order_errs(8) !== 0) begin errors++; $display("FAIL t4_order got=%0d exp=0", order_errs(8)); end
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t4_idle got=%b exp=0", busy_o); end
    endtask

    task automatic test_reset_mid_frame;
        int late_valid;
        do_start(16'h5555, 16'h6666, 16'h7777, 16'h8888);
        run_frame(0, 60, -1, 3);
        checks++; if (n_hs !== 3) begin errors++; $display("FAIL t5_pre_tiles got=%0d exp=3", n_hs); end
        rstn = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t5_busy got=%b exp=0", busy_o); end
        checks++; if (tif.tile_valid_o !== 1'b0) begin errors++; $display("FAIL t5_valid got=%b exp=0", tif.tile_valid_o); end
        checks++; if (tif.mem_rd_en_o !== 1'b0) begin errors++; $display("FAIL t5_rd_en got=%b exp=0", tif.mem_rd_en_o); end
        checks++; if (tif.mem_addr_o !== 8'h0) begin errors++; $display("FAIL t5_addr got=%0d exp=0", tif.mem_addr_o); end
        checks++; if (x_o !== 16'h0) begin errors++; $display("FAIL t5_x got=%h exp=0", x_o); end
        checks++; if (tif.B_tile_o !== 256'h0) begin errors++; $display("FAIL t5_B got=%h exp=0", tif.B_tile_o[15:0]); end
        @(negedge clk);
        rstn = 1'b1;
        late_valid = 0;
        repeat (4) begin
            @(negedge clk);
            if (tif.tile_valid_o) late_valid++;
        end
        checks++; if (late_valid !== 0) begin errors++; $display("FAIL t5_late_rdata got=%0d exp=0", late_valid); end
        do_start(16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        run_frame(0, 60, -1, 0);
        checks++; if (!done_seen) begin errors++; $display("FAIL t5_done got=0 exp=1"); end
        checks++; if (n_hs !== 8) begin errors++; $display("FAIL t5_tiles got=%0d exp=8", n_hs); end
        checks++; if (order_errs(8) !== 0) begin errors++; $display("FAIL t5_order got=%0d exp=0", order_errs(8)); end
        checks++; if (first_valid_c !== 3) begin errors++; $display("FAIL t5_first_valid got=%0d exp=3", first_valid_c); end
        checks++; if (x_o !== 16'hBBBB) begin errors++; $display("FAIL t5_x_new got=%h exp=bbbb", x_o); end
    endtask

`ifdef SSM_FEEDER_PERF_EN
    task automatic test_perf;
        do_start(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL t6_stall_clear got=%0d exp=0", stall_cnt_o); end
        checks++; if (starve_cnt_o !== 32'd0) begin errors++; $display("FAIL t6_starve_clear got=%0d exp=0", starve_cnt_o); end
        run_frame(1, 80, -1, 0);
        checks++; if (!done_seen) begin errors++; $display("FAIL t6_done got=0 exp=1"); end
        checks++; if (stall_cnt_o !== 32'(stall_seen)) begin errors++; $display("FAIL t6_stall got=%0d exp=%0d", stall_cnt_o, stall_seen); end
        checks++; if (starve_cnt_o !== 32'(starve_seen)) begin errors++; $display("FAIL t6_starve got=%0d exp=%0d", starve_cnt_o, starve_seen); end
        do_start(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL t6_stall_reclear got=%0d exp=0", stall_cnt_o); end
        run_frame(0, 60, -1, 0);
        checks++; if (!done_seen) begin errors++; $display("FAIL t6_done2 got=0 exp=1"); end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
`ifdef SSM_FEEDER_PERF_EN
        test_perf();
`endif
        test_ready_low();
        test_busy_start();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
